ddr3_burst_arbiter: RTL and testbench

- Parametrised successor of the DDR3 app-interface controller. Arbitrates write and read burst requests onto the MIG user interface (app_*).
- Generalises data width, address width, burst length and address step.
- Adds pipelined reads with up to MAX_OUT outstanding tagged bursts, write-starvation protection for reads, and tagged read-return framing (sop/eop).
- Sits between the packet write/read descriptor FIFOs and the DDR3 MIG core.

---
 rtl/ddr3_burst_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_ddr3_burst_arbiter.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_burst_arbiter.sv
// ddr3_burst_arbiter
// Arbitrates write and read burst descriptors onto the MIG app_* interface.
// Writes are favoured, but a starvation counter guarantees an eligible read a
// slot after WR_STARVE_MAX consecutive write grants. Reads are pipelined: up to
// MAX_OUT bursts may be outstanding, and their tags are queued so that returning
// data is framed with sop/eop and the tag of the burst it belongs to.
module ddr3_burst_arbiter #(
    parameter int DATA_W        = 512,
    parameter int ADDR_W        = 28,
    parameter int BURST         = 4,
    parameter int ADDR_STEP     = 8,
    parameter int TAG_W         = 4,
    parameter int MAX_OUT       = 4,
    parameter int WR_STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_req_empty,
    output logic                wr_req_rd,
    input  logic [ADDR_W-1:0]   wr_req_addr,
    input  logic                wr_dat_empty,
    output logic                wr_dat_rd,
    input  logic [DATA_W-1:0]   wr_dat_data,
    input  logic [8:0]          wr_dat_cnt,
    input  logic                rd_req_empty,
    output logic                rd_req_rd,
    input  logic [ADDR_W-1:0]   rd_req_addr,
    input  logic [TAG_W-1:0]    rd_req_tag,
    input  logic                rd_hold,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    output logic                app_en,
    output logic [2:0]          app_cmd,
    output logic [ADDR_W-1:0]   app_addr,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_rd_data_valid,
    input  logic [DATA_W-1:0]   app_rd_data,
    output logic                rd_out_valid,
    output logic [DATA_W-1:0]   rd_out_data,
    output logic [TAG_W-1:0]    rd_out_tag,
    output logic                rd_out_sop,
    output logic                rd_out_eop,
    output logic                err_unexp_rd
);

    localparam int CNT_W  = $clog2(BURST + 1);
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int STV_W  = $clog2(WR_STARVE_MAX + 1);
    localparam int PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WR_WAIT  = 2'd1;
    localparam logic [1:0] WR_BURST = 2'd2;
    localparam logic [1:0] RD_BURST = 2'd3;

    localparam logic [CNT_W-1:0]  BURST_C   = CNT_W'(BURST);
    localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(BURST - 1);
    localparam logic [OUT_W-1:0]  MAX_OUT_C = OUT_W'(MAX_OUT);
    localparam logic [STV_W-1:0]  STARVE_C  = STV_W'(WR_STARVE_MAX);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(MAX_OUT - 1);
    localparam logic [ADDR_W-1:0] STEP_C    = ADDR_W'(ADDR_STEP);
    localparam logic [8:0]        BURST_9   = 9'(BURST);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cmd_cnt;
    logic [CNT_W-1:0]  dat_cnt;
    logic [STV_W-1:0]  starve_cnt;
    logic [OUT_W-1:0]  outstanding;
    logic [TAG_W-1:0]  tag_mem [MAX_OUT];
    logic [PTR_W-1:0]  tag_wr_ptr;
    logic [PTR_W-1:0]  tag_rd_ptr;
    logic [BEAT_W-1:0] beat_cnt;

    logic rd_elig;
    logic wr_elig;
    logic grant_rd;
    logic grant_wr;
    logic cmd_acc;
    logic dat_acc;
    logic cmd_fin;
    logic dat_fin;
    logic rd_expected;
    logic rd_eop;

    assign rd_elig  = !rd_req_empty && !rd_hold && (outstanding < MAX_OUT_C);
    assign wr_elig  = !wr_req_empty;
    assign grant_rd = (state == IDLE) && rd_elig && (!wr_elig || starve_cnt == STARVE_C);
    assign grant_wr = (state == IDLE) && wr_elig && !grant_rd;

    assign cmd_acc = app_en && app_rdy;
    assign dat_acc = app_wdf_wren && app_wdf_rdy;
    assign cmd_fin = (cmd_cnt == BURST_C) || (cmd_acc && cmd_cnt == LAST_C);
    assign dat_fin = (dat_cnt == BURST_C) || (dat_acc && dat_cnt == LAST_C);

    assign rd_expected = app_rd_data_valid && (outstanding != '0);
    assign rd_eop      = rd_expected && (beat_cnt == BEAT_LAST);

    // Write data is shown straight from the show-ahead FIFO head and popped on acceptance.
    assign wr_dat_rd    = dat_acc;
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = app_wdf_wren ? wr_dat_data : '0;
    assign app_wdf_mask = '0;

    // Arbitration FSM plus command and write-data issue for the current burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cmd_cnt      <= '0;
            dat_cnt      <= '0;
            starve_cnt   <= '0;
            wr_req_rd    <= 1'b0;
            rd_req_rd    <= 1'b0;
            app_en       <= 1'b0;
            app_cmd      <= 3'b000;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            wr_req_rd <= 1'b0;
            rd_req_rd <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_rd) begin
                        rd_req_rd  <= 1'b1;
                        starve_cnt <= '0;
                        app_en     <= 1'b1;
                        app_cmd    <= 3'b001;
                        app_addr   <= rd_req_addr;
                        cmd_cnt    <= '0;
                        state      <= RD_BURST;
                    end else if (grant_wr) begin
                        wr_req_rd <= 1'b1;
                        app_cmd   <= 3'b000;
                        app_addr  <= wr_req_addr;
                        if (rd_elig) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (!wr_dat_empty && wr_dat_cnt >= BURST_9) begin
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        cmd_cnt      <= '0;
                        dat_cnt      <= '0;
                        state        <= WR_BURST;
                    end
                end
                WR_BURST: begin
                    if (cmd_acc) begin
                        cmd_cnt <= cmd_cnt + 1'b1;
                        if (cmd_cnt == LAST_C) begin
                            app_en <= 1'b0;
                        end else begin
                            app_addr <= app_addr + STEP_C;
                        end
                    end
                    if (dat_acc) begin
                        dat_cnt <= dat_cnt + 1'b1;
                        if (dat_cnt == LAST_C) begin
                            app_wdf_wren <= 1'b0;
                        end
                    end
                    if (cmd_fin && dat_fin) begin
                        state <= IDLE;
                    end
                end
                RD_BURST: begin
                    if (cmd_acc) begin
                        cmd_cnt <= cmd_cnt + 1'b1;
                        if (cmd_cnt == LAST_C) begin
                            app_en <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            app_addr <= app_addr + STEP_C;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO, outstanding-burst count and registered read-return framing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_mem[i] <= '0;
            end
            tag_wr_ptr   <= '0;
            tag_rd_ptr   <= '0;
            outstanding  <= '0;
            beat_cnt     <= '0;
            rd_out_valid <= 1'b0;
            rd_out_data  <= '0;
            rd_out_tag   <= '0;
            rd_out_sop   <= 1'b0;
            rd_out_eop   <= 1'b0;
            err_unexp_rd <= 1'b0;
        end else begin
            if (grant_rd) begin
                tag_mem[tag_wr_ptr] <= rd_req_tag;
                tag_wr_ptr <= (tag_wr_ptr == PTR_LAST) ? '0 : tag_wr_ptr + 1'b1;
            end
            if (rd_eop) begin
                tag_rd_ptr <= (tag_rd_ptr == PTR_LAST) ? '0 : tag_rd_ptr + 1'b1;
            end
            case ({grant_rd, rd_eop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            rd_out_valid <= app_rd_data_valid;
            rd_out_sop   <= 1'b0;
            rd_out_eop   <= 1'b0;
            if (app_rd_data_valid) begin
                rd_out_data <= app_rd_data;
                if (rd_expected) begin
                    rd_out_tag <= tag_mem[tag_rd_ptr];
                    rd_out_sop <= (beat_cnt == '0);
                    rd_out_eop <= (beat_cnt == BEAT_LAST);
                    beat_cnt   <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + 1'b1;
                end else begin
                    rd_out_tag   <= '0;
                    err_unexp_rd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_burst_arbiter.sv
// tb_ddr3_burst_arbiter
// Directed bench for ddr3_burst_arbiter. Bench-side queues stand in for the
// descriptor/data FIFOs; every handshake seen on the MIG side is logged and
// compared against hand-computed expectations.
module tb_ddr3_burst_arbiter;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_req_empty;
    logic          wr_req_rd;
    logic [AW-1:0] wr_req_addr;
    logic          wr_dat_empty;
    logic          wr_dat_rd;
    logic [DW-1:0] wr_dat_data;
    logic [8:0]    wr_dat_cnt;
    logic          rd_req_empty;
    logic          rd_req_rd;
    logic [AW-1:0] rd_req_addr;
    logic [TW-1:0] rd_req_tag;
    logic          rd_hold;
    logic          app_rdy;
    logic          app_wdf_rdy;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_wdf_wren;
    logic          app_wdf_end;
    logic [DW-1:0] app_wdf_data;
    logic [DW/8-1:0] app_wdf_mask;
    logic          app_rd_data_valid;
    logic [DW-1:0] app_rd_data;
    logic          rd_out_valid;
    logic [DW-1:0] rd_out_data;
    logic [TW-1:0] rd_out_tag;
    logic          rd_out_sop;
    logic          rd_out_eop;
    logic          err_unexp_rd;

    int n_check = 0;
    int n_pass  = 0;

    // Bench-side FIFO contents
    logic [AW-1:0] wrq[$];
    logic [DW-1:0] wdq[$];
    logic [AW-1:0] rdq_addr[$];
    logic [TW-1:0] rdq_tag[$];

    // Observation logs
    logic [AW-1:0] cmd_addr_q[$];
    logic [2:0]    cmd_type_q[$];
    logic [DW-1:0] wbeat_q[$];
    logic [DW-1:0] rdat_q[$];
    logic [TW-1:0] rtag_q[$];
    logic          rsop_q[$];
    logic          reop_q[$];
    int n_wr_req_rd;
    int n_wr_dat_rd;
    int n_rd_req_rd;

    ddr3_burst_arbiter #(.DATA_W(DW), .ADDR_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .wr_req_empty(wr_req_empty), .wr_req_rd(wr_req_rd), .wr_req_addr(wr_req_addr),
        .wr_dat_empty(wr_dat_empty), .wr_dat_rd(wr_dat_rd), .wr_dat_data(wr_dat_data),
        .wr_dat_cnt(wr_dat_cnt),
        .rd_req_empty(rd_req_empty), .rd_req_rd(rd_req_rd), .rd_req_addr(rd_req_addr),
        .rd_req_tag(rd_req_tag), .rd_hold(rd_hold),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_cmd(app_cmd),
        .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_rd_data_valid(app_rd_data_valid), .app_rd_data(app_rd_data),
        .rd_out_valid(rd_out_valid), .rd_out_data(rd_out_data), .rd_out_tag(rd_out_tag),
        .rd_out_sop(rd_out_sop), .rd_out_eop(rd_out_eop), .err_unexp_rd(err_unexp_rd)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop so a wedged run still terminates with a visible failure
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic refresh();
        wr_req_empty = (wrq.size() == 0);
        wr_req_addr  = (wrq.size() != 0) ? wrq[0] : '0;
        wr_dat_empty = (wdq.size() == 0);
        wr_dat_data  = (wdq.size() != 0) ? wdq[0] : '0;
        wr_dat_cnt   = 9'(wdq.size());
        rd_req_empty = (rdq_addr.size() == 0);
        rd_req_addr  = (rdq_addr.size() != 0) ? rdq_addr[0] : '0;
        rd_req_tag   = (rdq_tag.size() != 0) ? rdq_tag[0] : '0;
    endtask

    task automatic clear_logs();
        cmd_addr_q.delete(); cmd_type_q.delete(); wbeat_q.delete();
        rdat_q.delete(); rtag_q.delete(); rsop_q.delete(); reop_q.delete();
        n_wr_req_rd = 0; n_wr_dat_rd = 0; n_rd_req_rd = 0;
    endtask

    // One clock: observe handshakes mid-cycle, then pop FIFOs just after the edge
    task automatic tick();
        logic pw, pd, pr;
        @(negedge clk);
        pw = wr_req_rd; pd = wr_dat_rd; pr = rd_req_rd;
        if (app_en && app_rdy) begin
            cmd_addr_q.push_back(app_addr);
            cmd_type_q.push_back(app_cmd);
        end
        if (app_wdf_wren && app_wdf_rdy) wbeat_q.push_back(app_wdf_data);
        if (rd_out_valid) begin
            rdat_q.push_back(rd_out_data); rtag_q.push_back(rd_out_tag);
            rsop_q.push_back(rd_out_sop);  reop_q.push_back(rd_out_eop);
        end
        if (pw) n_wr_req_rd++;
        if (pd) n_wr_dat_rd++;
        if (pr) n_rd_req_rd++;
        @(posedge clk);
        #1;
        if (pw && wrq.size() != 0) void'(wrq.pop_front());
        if (pd && wdq.size() != 0) void'(wdq.pop_front());
        if (pr && rdq_addr.size() != 0) begin
            void'(rdq_addr.pop_front());
            void'(rdq_tag.pop_front());
        end
        refresh();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic return_beats(int n, logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data = base + DW'(i);
            tick();
        end
        app_rd_data_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] ctl;
        ticks(2);
        ctl = {app_en, wr_req_rd, rd_req_rd, wr_dat_rd, app_wdf_wren, app_wdf_end,
               rd_out_valid, rd_out_sop, rd_out_eop, err_unexp_rd};
        n_check++;
        if (ctl !== 10'b0) $display("[TB] FAIL reset_ctl: got %b expected 0", ctl);
        else n_pass++;
        n_check++;
        if (app_addr !== '0 || app_cmd !== 3'b000 || app_wdf_data !== '0 || app_wdf_mask !== '0 ||
            rd_out_data !== '0 || rd_out_tag !== '0)
            $display("[TB] FAIL reset_data: got addr=%0h cmd=%0h wdata=%0h mask=%0h rdata=%0h tag=%0h expected all 0",
                     app_addr, app_cmd, app_wdf_data, app_wdf_mask, rd_out_data, rd_out_tag);
        else n_pass++;
        reset = 1'b0;
        clear_logs();
        ticks(3);
        n_check++;
        if (app_en !== 1'b0 || cmd_addr_q.size() != 0)
            $display("[TB] FAIL idle_quiet: got app_en=%b cmds=%0d expected 0/0", app_en, cmd_addr_q.size());
        else n_pass++;
    endtask

    task automatic test_single_write();
        logic [AW-1:0] ea;
        clear_logs();
        wrq.push_back(28'h100);
        for (int i = 0; i < 4; i++) wdq.push_back(32'hA000_0000 + i);
        refresh();
        ticks(20);
        n_check++;
        if (cmd_addr_q.size() != 4) $display("[TB] FAIL wr_cmd_count: got %0d expected 4", cmd_addr_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            ea = 28'h100 + AW'(8 * i);
            n_check++;
            if (i >= cmd_addr_q.size() || cmd_addr_q[i] !== ea || cmd_type_q[i] !== 3'b000)
                $display("[TB] FAIL wr_cmd%0d: got %0h expected addr %0h cmd 0", i,
                         (i < cmd_addr_q.size()) ? cmd_addr_q[i] : '1, ea);
            else n_pass++;
        end
        n_check++;
        if (wbeat_q.size() != 4 || wbeat_q[0] !== 32'hA000_0000 || wbeat_q[1] !== 32'hA000_0001 ||
            wbeat_q[2] !== 32'hA000_0002 || wbeat_q[3] !== 32'hA000_0003)
            $display("[TB] FAIL wr_beats: got %0d beats first %0h expected 4 beats A0000000..3",
                     wbeat_q.size(), (wbeat_q.size() != 0) ? wbeat_q[0] : '1);
        else n_pass++;
        n_check++;
        if (n_wr_req_rd != 1 || n_wr_dat_rd != 4)
            $display("[TB] FAIL wr_pops: got req=%0d dat=%0d expected 1/4", n_wr_req_rd, n_wr_dat_rd);
        else n_pass++;
    endtask

    task automatic test_app_rdy_stall();
        bit seen = 0;
        clear_logs();
        wrq.push_back(28'h200);
        for (int i = 0; i < 4; i++) wdq.push_back(32'hC000_0000 + i);
        refresh();
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (cmd_addr_q.size() >= 1) seen = 1;
        end
        n_check++;
        if (!seen) $display("[TB] FAIL stall_first_cmd: got none expected 1 command within 20 cycles");
        else n_pass++;
        app_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_check++;
            if (app_en !== 1'b1 || app_addr !== 28'h208)
                $display("[TB] FAIL stall_hold%0d: got en=%b addr=%0h expected 1/208", k, app_en, app_addr);
            else n_pass++;
        end
        app_rdy = 1'b1;
        ticks(15);
        n_check++;
        if (cmd_addr_q.size() != 4 || cmd_addr_q[0] !== 28'h200 || cmd_addr_q[1] !== 28'h208 ||
            cmd_addr_q[2] !== 28'h210 || cmd_addr_q[3] !== 28'h218)
            $display("[TB] FAIL stall_cmds: got %0d cmds last %0h expected 4 cmds 200..218",
                     cmd_addr_q.size(), (cmd_addr_q.size() != 0) ? cmd_addr_q[cmd_addr_q.size()-1] : '1);
        else n_pass++;
    endtask

    task automatic test_read_tags();
        logic [AW-1:0] ea;
        logic [TW-1:0] et;
        clear_logs();
        rdq_addr.push_back(28'h1000); rdq_tag.push_back(4'd3);
        rdq_addr.push_back(28'h2000); rdq_tag.push_back(4'd5);
        rdq_addr.push_back(28'h3000); rdq_tag.push_back(4'd9);
        refresh();
        ticks(25);
        n_check++;
        if (cmd_addr_q.size() != 12) $display("[TB] FAIL rd_cmd_count: got %0d expected 12", cmd_addr_q.size());
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            ea = AW'(32'h1000 * (i / 4 + 1) + 8 * (i % 4));
            n_check++;
            if (i >= cmd_addr_q.size() || cmd_addr_q[i] !== ea || cmd_type_q[i] !== 3'b001)
                $display("[TB] FAIL rd_cmd%0d: got %0h expected addr %0h cmd 1", i,
                         (i < cmd_addr_q.size()) ? cmd_addr_q[i] : '1, ea);
            else n_pass++;
        end
        app_rd_data_valid = 1'b1;
        app_rd_data = 32'h5000_0000;
        tick();
        n_check++;
        if (rd_out_valid !== 1'b1 || rd_out_sop !== 1'b1 || rd_out_eop !== 1'b0 ||
            rd_out_tag !== 4'd3 || rd_out_data !== 32'h5000_0000)
            $display("[TB] FAIL rd_latency: got v=%b sop=%b eop=%b tag=%0h data=%0h expected 1/1/0/3/50000000",
                     rd_out_valid, rd_out_sop, rd_out_eop, rd_out_tag, rd_out_data);
        else n_pass++;
        return_beats(11, 32'h5000_0001);
        n_check++;
        if (rdat_q.size() != 12) $display("[TB] FAIL rd_beat_count: got %0d expected 12", rdat_q.size());
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            et = (i < 4) ? 4'd3 : (i < 8) ? 4'd5 : 4'd9;
            n_check++;
            if (i >= rdat_q.size() || rtag_q[i] !== et || rsop_q[i] !== (i % 4 == 0) ||
                reop_q[i] !== (i % 4 == 3) || rdat_q[i] !== 32'h5000_0000 + i)
                $display("[TB] FAIL rd_beat%0d: got tag=%0h sop=%b eop=%b expected tag=%0h sop=%b eop=%b", i,
                         (i < rtag_q.size()) ? rtag_q[i] : '1, (i < rsop_q.size()) ? rsop_q[i] : 1'bx,
                         (i < reop_q.size()) ? reop_q[i] : 1'bx, et, (i % 4 == 0), (i % 4 == 3));
            else n_pass++;
        end
    endtask

    task automatic test_max_out();
        int bad = 0;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            rdq_addr.push_back(AW'(32'h4000 + 32'h100 * i));
            rdq_tag.push_back(TW'(i + 1));
        end
        refresh();
        ticks(40);
        n_check++;
        if (cmd_addr_q.size() != 16 || n_rd_req_rd != 4 || rdq_addr.size() != 1)
            $display("[TB] FAIL maxout_limit: got cmds=%0d grants=%0d queued=%0d expected 16/4/1",
                     cmd_addr_q.size(), n_rd_req_rd, rdq_addr.size());
        else n_pass++;
        return_beats(4, 32'h6000_0000);
        ticks(15);
        n_check++;
        if (cmd_addr_q.size() != 20 || rdq_addr.size() != 0 || cmd_addr_q[16] !== 28'h4400)
            $display("[TB] FAIL maxout_fifth: got cmds=%0d queued=%0d expected 20/0 with 5th at 4400",
                     cmd_addr_q.size(), rdq_addr.size());
        else n_pass++;
        return_beats(16, 32'h6000_0004);
        for (int i = 0; i < 20; i++)
            if (i >= rtag_q.size() || rtag_q[i] !== TW'(i / 4 + 1)) bad++;
        n_check++;
        if (rtag_q.size() != 20 || bad != 0)
            $display("[TB] FAIL maxout_tags: got %0d beats with %0d bad tags expected 20/0", rtag_q.size(), bad);
        else n_pass++;
    endtask

    task automatic test_starvation();
        int first_rd = -1;
        int n_rd = 0;
        int bad = 0;
        clear_logs();
        for (int k = 0; k < 10; k++) wrq.push_back(AW'(32'h10000 + 32'h20 * k));
        for (int i = 0; i < 40; i++) wdq.push_back(32'hB000_0000 + i);
        rdq_addr.push_back(28'h8000); rdq_tag.push_back(4'd7);
        refresh();
        ticks(90);
        for (int i = 0; i < cmd_type_q.size(); i++) begin
            if (cmd_type_q[i] == 3'b001) begin
                n_rd++;
                if (first_rd < 0) first_rd = i;
            end
        end
        n_check++;
        if (cmd_addr_q.size() != 44 || first_rd != 32 || n_rd != 4 || cmd_addr_q[32] !== 28'h8000)
            $display("[TB] FAIL starve_grant: got cmds=%0d first_rd=%0d reads=%0d expected 44/32/4",
                     cmd_addr_q.size(), first_rd, n_rd);
        else n_pass++;
        for (int i = 0; i < 40; i++)
            if (i >= wbeat_q.size() || wbeat_q[i] !== 32'hB000_0000 + i) bad++;
        n_check++;
        if (wbeat_q.size() != 40 || bad != 0)
            $display("[TB] FAIL starve_wdata: got %0d beats %0d bad expected 40/0", wbeat_q.size(), bad);
        else n_pass++;
        return_beats(4, 32'h7000_0000);
        n_check++;
        if (rtag_q.size() != 4 || rtag_q[3] !== 4'd7 || reop_q[3] !== 1'b1)
            $display("[TB] FAIL starve_rdret: got %0d beats expected 4 with tag 7", rtag_q.size());
        else n_pass++;

        clear_logs();
        rd_hold = 1'b1;
        for (int k = 0; k < 10; k++) wrq.push_back(AW'(32'h20000 + 32'h20 * k));
        for (int i = 0; i < 40; i++) wdq.push_back(32'hD000_0000 + i);
        rdq_addr.push_back(28'h9000); rdq_tag.push_back(4'hA);
        refresh();
        ticks(90);
        n_rd = 0;
        for (int i = 0; i < cmd_type_q.size(); i++) if (cmd_type_q[i] == 3'b001) n_rd++;
        n_check++;
        if (cmd_addr_q.size() != 40 || n_rd != 0 || rdq_addr.size() != 1)
            $display("[TB] FAIL hold_blocks: got cmds=%0d reads=%0d queued=%0d expected 40/0/1",
                     cmd_addr_q.size(), n_rd, rdq_addr.size());
        else n_pass++;
        rd_hold = 1'b0;
        ticks(10);
        n_check++;
        if (cmd_addr_q.size() != 44 || rdq_addr.size() != 0 || cmd_addr_q[43] !== 28'h9018 ||
            cmd_type_q[43] !== 3'b001)
            $display("[TB] FAIL hold_release: got cmds=%0d queued=%0d expected 44/0 ending at 9018",
                     cmd_addr_q.size(), rdq_addr.size());
        else n_pass++;
        return_beats(4, 32'h7100_0000);
        n_check++;
        if (rtag_q.size() != 4 || rtag_q[0] !== 4'hA || rsop_q[0] !== 1'b1)
            $display("[TB] FAIL hold_rdret: got %0d beats expected 4 with tag A", rtag_q.size());
        else n_pass++;
    endtask

    task automatic test_unexpected();
        n_check++;
        if (err_unexp_rd !== 1'b0) $display("[TB] FAIL unexp_pre: got %b expected 0", err_unexp_rd);
        else n_pass++;
        app_rd_data_valid = 1'b1;
        app_rd_data = 32'hDEAD_BEEF;
        tick();
        app_rd_data_valid = 1'b0;
        n_check++;
        if (err_unexp_rd !== 1'b1 || rd_out_valid !== 1'b1 || rd_out_tag !== 4'd0 ||
            rd_out_data !== 32'hDEAD_BEEF)
            $display("[TB] FAIL unexp_set: got err=%b v=%b tag=%0h data=%0h expected 1/1/0/deadbeef",
                     err_unexp_rd, rd_out_valid, rd_out_tag, rd_out_data);
        else n_pass++;
        ticks(3);
        n_check++;
        if (err_unexp_rd !== 1'b1) $display("[TB] FAIL unexp_sticky: got %b expected 1", err_unexp_rd);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        bit seen = 0;
        logic [9:0] ctl;
        clear_logs();
        app_rdy = 1'b0;
        app_wdf_rdy = 1'b0;
        wrq.push_back(28'h300);
        for (int i = 0; i < 4; i++) wdq.push_back(32'hE000_0000 + i);
        refresh();
        for (int k = 0; k < 10 && !seen; k++) begin
            tick();
            if (app_en === 1'b1 && app_wdf_wren === 1'b1) seen = 1;
        end
        n_check++;
        if (!seen) $display("[TB] FAIL mid_enter: got no burst expected app_en within 10 cycles");
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        #1;
        ctl = {app_en, wr_req_rd, rd_req_rd, wr_dat_rd, app_wdf_wren, app_wdf_end,
               rd_out_valid, rd_out_sop, rd_out_eop, err_unexp_rd};
        n_check++;
        if (ctl !== 10'b0 || app_addr !== '0 || app_wdf_data !== '0)
            $display("[TB] FAIL mid_reset: got ctl=%b addr=%0h wdata=%0h expected 0", ctl, app_addr, app_wdf_data);
        else n_pass++;
        wrq.delete();
        wdq.delete();
        refresh();
        ticks(2);
        reset = 1'b0;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        clear_logs();
        wrq.push_back(28'h400);
        for (int i = 0; i < 4; i++) wdq.push_back(32'hF000_0000 + i);
        refresh();
        ticks(20);
        n_check++;
        if (cmd_addr_q.size() != 4 || cmd_addr_q[0] !== 28'h400 || cmd_addr_q[3] !== 28'h418 ||
            wbeat_q.size() != 4 || wbeat_q[0] !== 32'hF000_0000)
            $display("[TB] FAIL post_reset_write: got cmds=%0d beats=%0d expected 4/4 from 400",
                     cmd_addr_q.size(), wbeat_q.size());
        else n_pass++;
    endtask

    // Test sequence
    initial begin
        reset = 1'b1;
        app_rdy = 1'b1;
        app_wdf_rdy = 1'b1;
        rd_hold = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
        clear_logs();
        refresh();
        $display("[TB] starting ddr3_burst_arbiter bench");
        test_reset();
        test_single_write();
        test_app_rdy_stall();
        test_read_tags();
        test_max_out();
        test_starvation();
        test_unexpected();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
